mac_unit: RTL and testbench

MAC_UNIT -- requirements
Module: mac_unit

---
 rtl/mac_unit.sv | 64 ++++++
 tb/tb_mac_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mac_unit.sv
// Signed multiply-accumulate unit with saturating accumulator and a sticky
// overflow flag. One full-precision product is added per cycle while run is
// high; clr zeroes the accumulator and flag synchronously, rst_n asynchronously.
module mac_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          run,
    input  logic signed [DATA_WIDTH-1:0]  in1,
    input  logic signed [DATA_WIDTH-1:0]  in2,
    output logic signed [ACCUM_WIDTH-1:0] total,
    output logic                          err
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    // Saturation limits of the signed accumulator.
    localparam logic signed [ACCUM_WIDTH-1:0] MAX_VAL = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH-1:0] MIN_VAL = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [ACCUM_WIDTH-1:0] product_ext;
    logic        [ACCUM_WIDTH:0]   sum_wide;
    logic                          pos_ovf;
    logic                          neg_ovf;
    logic signed [ACCUM_WIDTH-1:0] next_total;

    // Full-precision product, sign-extended, then added one bit wider than the
    // accumulator so the true sign of the sum is still visible for saturation.
    always_comb begin
        product     = PROD_WIDTH'(in1) * PROD_WIDTH'(in2);
        product_ext = ACCUM_WIDTH'(product);
        sum_wide    = {total[ACCUM_WIDTH-1], total}
                    + {product_ext[ACCUM_WIDTH-1], product_ext};
        // The extra top bit is the real sign; disagreement with the accumulator
        // sign bit means the result does not fit in ACCUM_WIDTH bits.
        pos_ovf     = ~sum_wide[ACCUM_WIDTH] &  sum_wide[ACCUM_WIDTH-1];
        neg_ovf     =  sum_wide[ACCUM_WIDTH] & ~sum_wide[ACCUM_WIDTH-1];
        next_total  = sum_wide[ACCUM_WIDTH-1:0];
        if (pos_ovf) begin
            next_total = MAX_VAL;
        end else if (neg_ovf) begin
            next_total = MIN_VAL;
        end
    end

    // Accumulator and sticky error register; clr outranks run, reset outranks all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            total <= '0;
            err   <= 1'b0;
        end else if (run) begin
            total <= next_total;
            err   <= err | pos_ovf | neg_ovf;
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Directed testbench for mac_unit at default widths (8-bit operands, 16-bit
// accumulator). Inputs change 1 time unit after each rising edge and outputs
// are sampled at that same point, well away from the next active edge.
module tb_mac_unit;

    logic               clk;
    logic               rst_n;
    logic               clr;
    logic               run;
    logic signed [7:0]  in1;
    logic signed [7:0]  in2;
    logic signed [15:0] total;
    logic               err;

    int compare_count = 0;
    int fail_count    = 0;

    mac_unit #(
        .DATA_WIDTH  (8),
        .ACCUM_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .run   (run),
        .in1   (in1),
        .in2   (in2),
        .total (total),
        .err   (err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic r,
                                 input logic signed [7:0] a,
                                 input logic signed [7:0] b);
        clr = c;
        run = r;
        in1 = a;
        in2 = b;
    endtask

    // Compare both outputs against hand-computed expectations.
    task automatic checkOutput(input string tag,
                               input logic [15:0] exp_total,
                               input logic exp_err);
        compare_count++;
        assert (total === exp_total) else begin
            fail_count++;
            $error("[TB] FAIL %s.total: observed %h expected %h", tag, total, exp_total);
        end
        compare_count++;
        assert (err === exp_err) else begin
            fail_count++;
            $error("[TB] FAIL %s.err: observed %b expected %b", tag, err, exp_err);
        end
    endtask

    initial begin
        // Reset held with all-ones operands and run low.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'shFF, 8'shFF);
        #1;
        checkOutput("reset_start", 16'h0000, 1'b0);
        stepCycles(50);
        checkOutput("reset_mid", 16'h0000, 1'b0);
        stepCycles(50);
        checkOutput("reset_100", 16'h0000, 1'b0);

        // Release reset, run low: accumulator must hold zero.
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'sd1, 8'sd1);
        stepCycles(100);
        checkOutput("idle_hold", 16'h0000, 1'b0);

        // 90 cycles of 1*1, then hold, then a one-cycle clear.
        applyStimulus(1'b0, 1'b1, 8'sd1, 8'sd1);
        stepCycles(1);
        checkOutput("acc_first", 16'h0001, 1'b0);
        stepCycles(89);
        applyStimulus(1'b0, 1'b0, 8'sd1, 8'sd1);
        checkOutput("acc_90", 16'h005A, 1'b0);
        stepCycles(10);
        checkOutput("acc_90_hold", 16'h005A, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'sd1, 8'sd1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'sd1, 8'sd1);
        checkOutput("clr_zero", 16'h0000, 1'b0);
        stepCycles(5);
        checkOutput("clr_hold", 16'h0000, 1'b0);

        // -128 * -128 = +16384: positive saturation on the second add.
        applyStimulus(1'b0, 1'b1, -8'sd128, -8'sd128);
        stepCycles(1);
        checkOutput("negneg_1", 16'h4000, 1'b0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, -8'sd128, -8'sd128);
        checkOutput("negneg_sat", 16'h7FFF, 1'b1);
        stepCycles(5);
        checkOutput("negneg_sticky", 16'h7FFF, 1'b1);

        // Accumulating further from saturation stays clamped.
        applyStimulus(1'b0, 1'b1, -8'sd128, -8'sd128);
        stepCycles(1);
        checkOutput("sat_again", 16'h7FFF, 1'b1);
        // 32767 - 16256 = 16511 (0x407F): in range, but err remains set.
        applyStimulus(1'b0, 1'b1, -8'sd128, 8'sd127);
        stepCycles(1);
        checkOutput("sat_back_in_range", 16'h407F, 1'b1);

        // Clear, then 127*127 = 16129 three times.
        applyStimulus(1'b1, 1'b0, 8'sd0, 8'sd0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'sd0, 8'sd0);
        stepCycles(5);
        checkOutput("clr_err_cleared", 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'sd127, 8'sd127);
        stepCycles(1);
        checkOutput("pospos_1", 16'h3F01, 1'b0);
        stepCycles(1);
        checkOutput("pospos_2", 16'h7E02, 1'b0);
        stepCycles(1);
        checkOutput("pospos_sat", 16'h7FFF, 1'b1);

        // Clear has priority over run.
        applyStimulus(1'b1, 1'b1, 8'sd127, 8'sd127);
        stepCycles(1);
        checkOutput("clr_over_run", 16'h0000, 1'b0);

        // -128 * 127 = -16256: negative saturation on the third add.
        applyStimulus(1'b0, 1'b1, -8'sd128, 8'sd127);
        stepCycles(1);
        checkOutput("negpos_1", 16'hC080, 1'b0);
        stepCycles(1);
        checkOutput("negpos_2", 16'h8100, 1'b0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, -8'sd128, 8'sd127);
        checkOutput("negpos_sat", 16'h8000, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'sd0, 8'sd0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'sd0, 8'sd0);
        checkOutput("negpos_clr", 16'h0000, 1'b0);

        // Asynchronous reset in the middle of an accumulation (3*3 = 9).
        applyStimulus(1'b0, 1'b1, 8'sd3, 8'sd3);
        stepCycles(3);
        checkOutput("pre_reset_acc", 16'h001B, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0000, 1'b0);
        stepCycles(4);
        checkOutput("reset_with_run", 16'h0000, 1'b0);
        #2;
        rst_n = 1'b1;
        stepCycles(1);
        checkOutput("restart_from_zero", 16'h0009, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'sd0, 8'sd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
